advance_fa_4bit: RTL and testbench

Registered 4-bit carry-lookahead adder ("advance" = lookahead carry): computes a + b + c_in with single-level generate/propagate logic and presents sum and carry-out from output registers. It is a leaf arithmetic block used wherever a small clocked adder with a deterministic one-cycle latency is needed. WIDTH is parameterised in 4-bit lookahead groups, with default 4.

---
 rtl/advance_fa_4bit_pkg.sv | 15 +
 rtl/advance_fa_4bit_cla_4bit.sv | 54 +++++
 rtl/advance_fa_4bit.sv | 54 +++++
 tb/tb_advance_fa_4bit.sv | 120 ++++++++++++
 4 files changed

// File: rtl/advance_fa_4bit_pkg.sv
// Shared constants for the registered carry-lookahead adder.
package advance_fa_4bit_pkg;

  // Width of one lookahead group; the operand width must be a multiple of this.
  localparam int unsigned GROUP = 4;

  // Value loaded into every output flop while rst_n is low.
  localparam logic RESET_BIT = 1'b0;

  // True when a requested operand width can be split into whole groups.
  function automatic bit width_ok(input int unsigned width);
    return (width >= GROUP) && ((width % GROUP) == 0);
  endfunction

endpackage

// File: rtl/advance_fa_4bit_cla_4bit.sv
// One 4-bit carry-lookahead group: flat two-level carries, sum, and the
// group propagate/generate pair for a future second lookahead level.
module cla_4bit
  import advance_fa_4bit_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  output logic [3:0] s,
  output logic       c4,
  output logic       P,
  output logic       G
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  // Bitwise generate and propagate terms.
  always_comb begin
    g = a & b;
    p = a ^ b;
  end

  // Every carry is a sum of products of g, p and c0; none depends on another carry.
  always_comb begin
    c[0] = c0;
    c[1] = g[0]
         | (p[0] & c0);
    c[2] = g[1]
         | (p[1] & g[0])
         | (p[1] & p[0] & c0);
    c[3] = g[2]
         | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c0);
    c4   = g[3]
         | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
  end

  // Sum bits and group signals; G is c4 evaluated with c0 held at zero.
  always_comb begin
    s = p ^ c;
    P = &p;
    G = g[3]
      | (p[3] & g[2])
      | (p[3] & p[2] & g[1])
      | (p[3] & p[2] & p[1] & g[0]);
  end

endmodule

// File: rtl/advance_fa_4bit.sv
// Registered adder: sum/c_out = a + b + c_in one clock after the inputs,
// built from WIDTH/4 lookahead groups with carries rippling between groups.
module advance_fa_4bit
  import advance_fa_4bit_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int unsigned NGROUPS = WIDTH / GROUP;

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("advance_fa_4bit: WIDTH must be a positive multiple of 4");
  end

  logic [NGROUPS:0]   carry;
  logic [WIDTH-1:0]   sum_next;
  // Group P/G are produced for a later second-level lookahead and not consumed yet.
  logic [NGROUPS-1:0] grp_p_unused;
  logic [NGROUPS-1:0] grp_g_unused;

  assign carry[0] = c_in;

  for (genvar gi = 0; gi < NGROUPS; gi++) begin : g_group
    cla_4bit u_cla (
      .a  (a[gi*GROUP +: GROUP]),
      .b  (b[gi*GROUP +: GROUP]),
      .c0 (carry[gi]),
      .s  (sum_next[gi*GROUP +: GROUP]),
      .c4 (carry[gi+1]),
      .P  (grp_p_unused[gi]),
      .G  (grp_g_unused[gi])
    );
  end

  // Output register; reset overrides the freshly computed result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum   <= {WIDTH{RESET_BIT}};
      c_out <= RESET_BIT;
    end else begin
      sum   <= sum_next;
      c_out <= carry[NGROUPS];
    end
  end

endmodule

// File: tb/tb_advance_fa_4bit.sv
// Self-checking bench for advance_fa_4bit at WIDTH = 4 and WIDTH = 8.
module tb_advance_fa_4bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a4, b4, sum4;
  logic       c4, cout4;
  logic [7:0] a8, b8, sum8;
  logic       c8, cout8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  advance_fa_4bit #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a4),
    .b     (b4),
    .c_in  (c4),
    .sum   (sum4),
    .c_out (cout4)
  );

  advance_fa_4bit #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a8),
    .b     (b8),
    .c_in  (c8),
    .sum   (sum8),
    .c_out (cout8)
  );

  // Reference: plain integer addition, zero while reset is applied.
  function automatic logic [4:0] ref4(input logic r, input logic [3:0] x, input logic [3:0] y, input logic ci);
    int unsigned t;
    t = int'(x) + int'(y) + int'(ci);
    return r ? 5'(t) : 5'd0;
  endfunction

  function automatic logic [8:0] ref8(input logic r, input logic [7:0] x, input logic [7:0] y, input logic ci);
    int unsigned t;
    t = int'(x) + int'(y) + int'(ci);
    return r ? 9'(t) : 9'd0;
  endfunction

  // Apply operands to both instances, clock once, check both one edge later.
  task automatic step(input string tag, input logic r,
                      input logic [3:0] x4, input logic [3:0] y4, input logic ci4,
                      input logic [7:0] x8, input logic [7:0] y8, input logic ci8);
    logic [4:0] e4;
    logic [8:0] e8;
    rst_n = r;
    a4 = x4; b4 = y4; c4 = ci4;
    a8 = x8; b8 = y8; c8 = ci8;
    e4 = ref4(r, x4, y4, ci4);
    e8 = ref8(r, x8, y8, ci8);
    @(posedge clk);
    #1;
    checks++;
    assert ({cout4, sum4} === e4) else begin
      errors++;
      $error("FAIL %s w4: a=%h b=%h cin=%0d got {c_out,sum}=%h want %h", tag, x4, y4, ci4, {cout4, sum4}, e4);
    end
    checks++;
    assert ({cout8, sum8} === e8) else begin
      errors++;
      $error("FAIL %s w8: a=%h b=%h cin=%0d got {c_out,sum}=%h want %h", tag, x8, y8, ci8, {cout8, sum8}, e8);
    end
  endtask

  logic [3:0] va [7] = '{4'b0001, 4'b0001, 4'b0000, 4'b1000, 4'b0111, 4'b0111, 4'b1101};
  logic [3:0] vb [7] = '{4'b0101, 4'b0111, 4'b1001, 4'b0110, 4'b1100, 4'b1111, 4'b0100};
  logic       vc [7] = '{1'b0,    1'b0,    1'b0,    1'b0,    1'b0,    1'b1,    1'b1};

  initial begin
    rst_n = 1'b0;
    a4 = '0; b4 = '0; c4 = 1'b0;
    a8 = '0; b8 = '0; c8 = 1'b0;
    #2;

    // Reset held for two edges with all-ones operands, then released.
    step("reset0", 1'b0, 4'hF, 4'hF, 1'b1, 8'hFF, 8'hFF, 1'b1);
    step("reset1", 1'b0, 4'hF, 4'hF, 1'b1, 8'hFF, 8'hFF, 1'b1);
    step("release", 1'b1, 4'hF, 4'hF, 1'b1, 8'hFF, 8'hFF, 1'b1);

    // Directed vectors, back-to-back every cycle.
    for (int i = 0; i < 7; i++)
      step("directed", 1'b1, va[i], vb[i], vc[i], {va[i], vb[i]}, {vb[i], va[i]}, vc[i]);

    // Full propagate through a group, with and without carry-in.
    step("prop_c1", 1'b1, 4'hF, 4'h0, 1'b1, 8'hFF, 8'h00, 1'b1);
    step("prop_c0", 1'b1, 4'hF, 4'h0, 1'b0, 8'hFF, 8'h00, 1'b0);

    // Reset in mid-stream discards the result, next edge resumes.
    step("stream_a", 1'b1, va[4], vb[4], vc[4], 8'h7F, 8'h81, 1'b0);
    step("stream_rst", 1'b0, va[5], vb[5], vc[5], 8'hC3, 8'h5A, 1'b1);
    step("stream_resume", 1'b1, va[6], vb[6], vc[6], 8'h80, 8'h80, 1'b1);

    // Exhaustive at WIDTH 4, random operands at WIDTH 8 alongside.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      step("exhaustive", 1'b1, v[7:4], v[3:0], v[8],
           8'($urandom), 8'($urandom), 1'($urandom));
    end

    // Random operands with occasional reset.
    for (int i = 0; i < 100; i++)
      step("random", ($urandom_range(0, 15) != 0),
           4'($urandom), 4'($urandom), 1'($urandom),
           8'($urandom), 8'($urandom), 1'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
